ip_ram_arbiter: RTL and testbench
=================================

# ip_ram_arbiter

Two-requester arbiter that sits directly downstream of `ip_mapperram` on its RAM I/F and shares one external RAM controller between the mapper RAM and a second RAM client (e.g. MegaROM/SCC buffer). It accepts single-cycle rd/wr pulses from each port and buffers one request per port. It grants the memory side round-robin and routes read data back to the issuing port. A watchdog guarantees every accepted read completes.

## Interface
- `TIMEOUT`, 64: cycles to wait for `mem_rdata_en` before forcing a read completion.
- `n_reset`  in  1  asynchronous active-low reset
- `clk`  in  1  system clock (21.477 MHz)
- `a_rd`, `a_wr`  in  1  port A (mapperram) request pulses; legal only while `a_busy`=0
- `a_busy`  out  1  port A request outstanding
- `a_address`  in  22  port A byte address
- `a_wdata`  in  8  port A write data
- `a_rdata`  out  8  port A read data
- `a_rdata_en`  out  1  port A read data valid, one cycle
- `b_rd`, `b_wr`, `b_busy`, `b_address`, `b_wdata`, `b_rdata`, `b_rdata_en`: same as port A, for port B
- `mem_rd`, `mem_wr`  out  1  memory request pulses
- `mem_busy`  in  1  memory controller cannot accept a request
- `mem_address`  out  22  memory address
- `mem_wdata`  out  8  memory write data
- `mem_rdata`  in  8  memory read data
- `mem_rdata_en`  in  1  memory read data valid

## Operation
- Port buffer: a cycle with rd or wr =1 and busy=0 captures kind, address and wdata. busy=1 from the next cycle. A pulse while busy=1 is dropped with no side effects. rd and wr both set: treated as rd.
- State machine: ST_IDLE, ST_WAIT_READ.
- ST_IDLE: if any buffer is pending and `mem_busy`=0, grant one port.
  - Round-robin: `last_grant` flips to the granted port. Reset value = B, so A wins the first tie.
  - Drive `mem_rd` or `mem_wr` for exactly one cycle with that port's address/wdata.
  - Write: clear the port buffer at the same edge (busy falls); stay in ST_IDLE.
  - Read: record the owner; go to ST_WAIT_READ.
- ST_WAIT_READ: on `mem_rdata_en`=1, register `mem_rdata` to the owner's rdata and pulse the owner's rdata_en, clear the owner's busy, return to ST_IDLE. No new grant is issued in this state.
- Watchdog: counter cleared on entry to ST_WAIT_READ. If it reaches `TIMEOUT` with no `mem_rdata_en`, complete the read with rdata=8'hFF.
- `mem_rdata_en` while in ST_IDLE is ignored. This covers stale data after a timeout or reset.
- Reset values: all busy=0, rdata=8'h00, rdata_en=0, mem_rd=mem_wr=0, mem_address=0, mem_wdata=0, state ST_IDLE, counter=0, last_grant=B.
- Reset mid-operation clears all buffers and any owner; the in-flight read is never reported.

## Timing
- Request accepted at edge E0: busy=1 from E0.
- Earliest `mem_rd`/`mem_wr` is the cycle after E0, if `mem_busy`=0 and ST_IDLE. Address is stable during the pulse.
- Write: busy falls at the edge that ends the `mem_wr` cycle. Minimum port occupancy is 2 cycles.
- Read: `mem_rdata_en` at cycle R gives port rdata_en=1 and busy=0 at cycle R+1. rdata holds its value until the next completion.
- Back-to-back writes from A and B pending together: A issues at cycle N, B at N+1.
- `mem_busy`=1 stalls the grant indefinitely; requests stay buffered.
- Timeout read: rdata_en occurs `TIMEOUT`+1 cycles after `mem_rd`.

## Structure
- Package `ram_arb_pkg` holds:
  - the state enum (ST_IDLE, ST_WAIT_READ)
  - port index constants (PORT_A=0, PORT_B=1)
  - the request struct (kind, 22-bit address, 8-bit wdata)
  - the default timeout-fill constant 8'hFF
- Sub-module `ip_ram_arbiter_port` holds the one-entry request buffer with its busy flag and return-data registers. It is instantiated twice.
- Top level holds the FSM, round-robin logic, watchdog and memory-side drive.

## Test plan
- A write 22'h048000 / 8'h5A, `mem_busy`=0 -> one-cycle `mem_wr` with that address/data on the next cycle; `a_busy` high for exactly 2 cycles.
- A read 22'h2AC123, memory returns 8'h3C 3 cycles after `mem_rd` -> `a_rdata`=8'h3C with `a_rdata_en` one cycle later; `b_rdata_en` stays 0.
- A and B write in the same cycle, repeated twice:
  - first round: A issued first, then B on the following cycle
  - second round: B issued first
- `mem_busy` held 1 for 20 cycles with A and B pending -> no `mem_rd`/`mem_wr` during the stall; both requests issued after release, nothing lost.
- B read with no `mem_rdata_en` (`TIMEOUT`=64):
  - `b_rdata`=8'hFF and `b_rdata_en` at `mem_rd`+65
  - a later stray `mem_rdata_en` produces no port rdata_en
- `n_reset` pulsed low while in ST_WAIT_READ -> all outputs return to reset values immediately; a subsequent `mem_rdata_en` is ignored; a new A request is served normally.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// Imported by the arbiter top and by its per-port request buffer.
package ram_arb_pkg;

   localparam int ADDR_W = 22;
   localparam int DATA_W = 8;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   // Data returned to the owner when the memory never answers a read
   localparam logic [DATA_W-1:0] TIMEOUT_FILL = 8'hFF;

   typedef enum logic {
      ST_IDLE,
      ST_WAIT_READ
   } state_t;

   typedef enum logic {
      REQ_READ,
      REQ_WRITE
   } req_kind_t;

   typedef struct packed {
      req_kind_t           kind;
      logic [ADDR_W-1:0]   address;
      logic [DATA_W-1:0]   wdata;
   } req_t;

endpackage

// File: rtl/ip_ram_arbiter_port.sv
// One-entry request buffer for a single client, including its busy flag
// and the registered read-return path back to that client.
module ip_ram_arbiter_port
   import ram_arb_pkg::*;
(
   input  logic              clk,
   input  logic              n_reset,
   input  logic              rd,
   input  logic              wr,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] wdata,
   input  logic              clear,
   input  logic              done,
   input  logic [DATA_W-1:0] done_data,
   output logic              busy,
   output req_t              req,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_en
);

   // Pulses while busy are dropped; done only ever targets a busy buffer,
   // so it never collides with a capture.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         busy     <= 1'b0;
         req      <= '{kind: REQ_READ, address: '0, wdata: '0};
         rdata    <= '0;
         rdata_en <= 1'b0;
      end else begin
         rdata_en <= 1'b0;
         if (!busy && (rd || wr)) begin
            busy        <= 1'b1;
            req.kind    <= rd ? REQ_READ : REQ_WRITE;
            req.address <= address;
            req.wdata   <= wdata;
         end else if (clear) begin
            busy <= 1'b0;
         end
         if (done) begin
            rdata    <= done_data;
            rdata_en <= 1'b1;
            busy     <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/ip_ram_arbiter.sv
// Shares one RAM controller between two clients: round-robin grant,
// read data routed back to the issuing port, watchdog-bounded reads.
module ip_ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int TIMEOUT = 64
)(
   input  logic              n_reset,
   input  logic              clk,
   input  logic              a_rd,
   input  logic              a_wr,
   output logic              a_busy,
   input  logic [ADDR_W-1:0] a_address,
   input  logic [DATA_W-1:0] a_wdata,
   output logic [DATA_W-1:0] a_rdata,
   output logic              a_rdata_en,
   input  logic              b_rd,
   input  logic              b_wr,
   output logic              b_busy,
   input  logic [ADDR_W-1:0] b_address,
   input  logic [DATA_W-1:0] b_wdata,
   output logic [DATA_W-1:0] b_rdata,
   output logic              b_rdata_en,
   output logic              mem_rd,
   output logic              mem_wr,
   input  logic              mem_busy,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_rdata_en
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_t            state;
   logic              grant_port;
   logic              last_grant;
   logic [CNT_W-1:0]  count;
   req_t              a_req;
   req_t              b_req;
   req_t              sel_req;
   logic              a_elig;
   logic              b_elig;
   logic              grant_valid;
   logic              sel;
   logic              read_done;
   logic [DATA_W-1:0] done_data;
   logic              a_done;
   logic              b_done;
   logic              a_clear;
   logic              b_clear;

   // A write being pulsed this cycle still shows busy until the closing
   // edge, so it is masked out of arbitration to avoid a double issue.
   always_comb begin
      a_elig      = a_busy && !(mem_wr && grant_port == PORT_A);
      b_elig      = b_busy && !(mem_wr && grant_port == PORT_B);
      grant_valid = a_elig || b_elig;
      if (a_elig && b_elig) begin
         sel = ~last_grant;
      end else if (a_elig) begin
         sel = PORT_A;
      end else begin
         sel = PORT_B;
      end
      sel_req   = (sel == PORT_A) ? a_req : b_req;
      read_done = (state == ST_WAIT_READ) && (mem_rdata_en || count == CNT_W'(TIMEOUT));
      done_data = mem_rdata_en ? mem_rdata : TIMEOUT_FILL;
      a_done    = read_done && grant_port == PORT_A;
      b_done    = read_done && grant_port == PORT_B;
      a_clear   = mem_wr && grant_port == PORT_A;
      b_clear   = mem_wr && grant_port == PORT_B;
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state       <= ST_IDLE;
         mem_rd      <= 1'b0;
         mem_wr      <= 1'b0;
         mem_address <= '0;
         mem_wdata   <= '0;
         grant_port  <= PORT_A;
         last_grant  <= PORT_B;
         count       <= '0;
      end else begin
         mem_rd <= 1'b0;
         mem_wr <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (grant_valid && !mem_busy) begin
                  grant_port  <= sel;
                  last_grant  <= sel;
                  mem_address <= sel_req.address;
                  mem_wdata   <= sel_req.wdata;
                  if (sel_req.kind == REQ_READ) begin
                     mem_rd <= 1'b1;
                     count  <= '0;
                     state  <= ST_WAIT_READ;
                  end else begin
                     mem_wr <= 1'b1;
                  end
               end
            end
            ST_WAIT_READ: begin
               if (read_done) begin
                  state <= ST_IDLE;
               end else begin
                  count <= count + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   ip_ram_arbiter_port u_port_a (
      .clk       (clk),
      .n_reset   (n_reset),
      .rd        (a_rd),
      .wr        (a_wr),
      .address   (a_address),
      .wdata     (a_wdata),
      .clear     (a_clear),
      .done      (a_done),
      .done_data (done_data),
      .busy      (a_busy),
      .req       (a_req),
      .rdata     (a_rdata),
      .rdata_en  (a_rdata_en)
   );

   ip_ram_arbiter_port u_port_b (
      .clk       (clk),
      .n_reset   (n_reset),
      .rd        (b_rd),
      .wr        (b_wr),
      .address   (b_address),
      .wdata     (b_wdata),
      .clear     (b_clear),
      .done      (b_done),
      .done_data (done_data),
      .busy      (b_busy),
      .req       (b_req),
      .rdata     (b_rdata),
      .rdata_en  (b_rdata_en)
   );

endmodule

// File: tb/tb_ip_ram_arbiter.sv
// Scoreboard bench for ip_ram_arbiter: directed requests push expected
// memory pulses and port completions, a negedge monitor pops and compares.
module tb_ip_ram_arbiter;

   localparam int TIMEOUT = 64;
   localparam int EV_WR = 0;
   localparam int EV_RD = 1;
   localparam int EV_A  = 2;
   localparam int EV_B  = 3;

   logic        clk = 1'b0;
   logic        n_reset;
   logic        a_rd, a_wr, b_rd, b_wr;
   logic [21:0] a_address, b_address;
   logic [7:0]  a_wdata, b_wdata;
   logic        a_busy, b_busy, a_rdata_en, b_rdata_en;
   logic [7:0]  a_rdata, b_rdata;
   logic        mem_rd, mem_wr, mem_busy, mem_rdata_en;
   logic [21:0] mem_address;
   logic [7:0]  mem_wdata, mem_rdata;

   typedef struct {
      int          kind;
      logic [21:0] addr;
      logic [7:0]  data;
      int          at;
   } ev_t;

   ev_t exp_q[$];
   int  vectors = 0;
   int  errors  = 0;
   int  cyc     = 0;
   int  c;

   ip_ram_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .n_reset      (n_reset),
      .clk          (clk),
      .a_rd         (a_rd),
      .a_wr         (a_wr),
      .a_busy       (a_busy),
      .a_address    (a_address),
      .a_wdata      (a_wdata),
      .a_rdata      (a_rdata),
      .a_rdata_en   (a_rdata_en),
      .b_rd         (b_rd),
      .b_wr         (b_wr),
      .b_busy       (b_busy),
      .b_address    (b_address),
      .b_wdata      (b_wdata),
      .b_rdata      (b_rdata),
      .b_rdata_en   (b_rdata_en),
      .mem_rd       (mem_rd),
      .mem_wr       (mem_wr),
      .mem_busy     (mem_busy),
      .mem_address  (mem_address),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_rdata_en (mem_rdata_en)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_ev(input int kind, input logic [21:0] addr, input logic [7:0] data, input int at);
      ev_t e;
      e.kind = kind;
      e.addr = addr;
      e.data = data;
      e.at   = at;
      exp_q.push_back(e);
   endtask

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
      vectors++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, required);
      end
   endtask

   task automatic compare_event(input int kind, input logic [21:0] addr, input logic [7:0] data);
      ev_t e;
      vectors++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("[TB] FAIL unexpected_event: got kind %0d addr %06h data %02h cycle %0d, expected none",
                  kind, addr, data, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.addr !== addr || e.data !== data || e.at != cyc) begin
            errors++;
            $display("[TB] FAIL event: got kind %0d addr %06h data %02h cycle %0d, expected kind %0d addr %06h data %02h cycle %0d",
                     kind, addr, data, cyc, e.kind, e.addr, e.data, e.at);
         end
      end
   endtask

   // Monitor: every memory pulse or port completion must match the queue head
   always @(negedge clk) begin
      if (n_reset) begin
         if (mem_wr)     compare_event(EV_WR, mem_address, mem_wdata);
         if (mem_rd)     compare_event(EV_RD, mem_address, 8'h00);
         if (a_rdata_en) compare_event(EV_A, 22'h0, a_rdata);
         if (b_rdata_en) compare_event(EV_B, 22'h0, b_rdata);
      end
   end

   task automatic apply_stimulus(input logic ard, input logic awr, input logic [21:0] aaddr, input logic [7:0] awd,
                                 input logic brd, input logic bwr, input logic [21:0] baddr, input logic [7:0] bwd);
      a_rd = ard;  a_wr = awr;  a_address = aaddr;  a_wdata = awd;
      b_rd = brd;  b_wr = bwr;  b_address = baddr;  b_wdata = bwd;
      @(negedge clk);
      a_rd = 1'b0; a_wr = 1'b0; b_rd = 1'b0; b_wr = 1'b0;
   endtask

   task automatic mem_return(input logic [7:0] d);
      mem_rdata    = d;
      mem_rdata_en = 1'b1;
      @(negedge clk);
      mem_rdata_en = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: got %0d events pending, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_output({tag, "_a_busy"}, 32'(a_busy), 32'h0);
      check_output({tag, "_b_busy"}, 32'(b_busy), 32'h0);
      check_output({tag, "_a_rdata"}, 32'(a_rdata), 32'h0);
      check_output({tag, "_b_rdata"}, 32'(b_rdata), 32'h0);
      check_output({tag, "_a_rdata_en"}, 32'(a_rdata_en), 32'h0);
      check_output({tag, "_b_rdata_en"}, 32'(b_rdata_en), 32'h0);
      check_output({tag, "_mem_rd"}, 32'(mem_rd), 32'h0);
      check_output({tag, "_mem_wr"}, 32'(mem_wr), 32'h0);
      check_output({tag, "_mem_address"}, 32'(mem_address), 32'h0);
      check_output({tag, "_mem_wdata"}, 32'(mem_wdata), 32'h0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got simulation time limit, expected completion");
      $fatal(1, "[TB] time limit reached");
   end

   initial begin
      n_reset = 1'b0;
      a_rd = 1'b0; a_wr = 1'b0; a_address = '0; a_wdata = '0;
      b_rd = 1'b0; b_wr = 1'b0; b_address = '0; b_wdata = '0;
      mem_busy = 1'b0; mem_rdata = '0; mem_rdata_en = 1'b0;
      step(3);
      check_reset_outputs("reset");
      n_reset = 1'b1;
      step(2);

      $display("[TB] simultaneous writes, round 1: A wins the first tie");
      c = cyc;
      expect_ev(EV_WR, 22'h000100, 8'h11, c + 2);
      expect_ev(EV_WR, 22'h3F0200, 8'h22, c + 3);
      apply_stimulus(1'b0, 1'b1, 22'h000100, 8'h11, 1'b0, 1'b1, 22'h3F0200, 8'h22);
      drain();

      $display("[TB] single A write");
      c = cyc;
      expect_ev(EV_WR, 22'h048000, 8'h5A, c + 2);
      apply_stimulus(1'b0, 1'b1, 22'h048000, 8'h5A, 1'b0, 1'b0, 22'h0, 8'h00);
      check_output("wr_busy_c1", 32'(a_busy), 32'h1);
      step(1);
      check_output("wr_busy_c2", 32'(a_busy), 32'h1);
      step(1);
      check_output("wr_busy_c3", 32'(a_busy), 32'h0);
      drain();

      $display("[TB] A read, memory answers 3 cycles after mem_rd");
      c = cyc;
      expect_ev(EV_RD, 22'h2AC123, 8'h00, c + 2);
      expect_ev(EV_A, 22'h0, 8'h3C, c + 6);
      apply_stimulus(1'b1, 1'b0, 22'h2AC123, 8'h00, 1'b0, 1'b0, 22'h0, 8'h00);
      step(4);
      check_output("rd_busy_wait", 32'(a_busy), 32'h1);
      mem_return(8'h3C);
      check_output("rd_busy_done", 32'(a_busy), 32'h0);
      check_output("rd_b_rdata_en", 32'(b_rdata_en), 32'h0);
      step(1);
      check_output("rd_a_rdata_en_off", 32'(a_rdata_en), 32'h0);
      check_output("rd_a_rdata_hold", 32'(a_rdata), 32'h3C);
      drain();

      // Last grant went to A, so the next tie favours B
      $display("[TB] simultaneous writes, round 2: B wins the tie");
      c = cyc;
      expect_ev(EV_WR, 22'h123456, 8'hB2, c + 2);
      expect_ev(EV_WR, 22'h0ABC00, 8'hA2, c + 3);
      apply_stimulus(1'b0, 1'b1, 22'h0ABC00, 8'hA2, 1'b0, 1'b1, 22'h123456, 8'hB2);
      drain();

      $display("[TB] mem_busy stall for 20 cycles");
      c = cyc;
      mem_busy = 1'b1;
      expect_ev(EV_WR, 22'h200002, 8'hBB, c + 21);
      expect_ev(EV_WR, 22'h100001, 8'hAA, c + 22);
      apply_stimulus(1'b0, 1'b1, 22'h100001, 8'hAA, 1'b0, 1'b1, 22'h200002, 8'hBB);
      step(18);
      check_output("stall_a_busy", 32'(a_busy), 32'h1);
      check_output("stall_b_busy", 32'(b_busy), 32'h1);
      step(1);
      mem_busy = 1'b0;
      drain();

      $display("[TB] B read with no memory answer");
      c = cyc;
      expect_ev(EV_RD, 22'h1F0F0F, 8'h00, c + 2);
      expect_ev(EV_B, 22'h0, 8'hFF, c + 2 + TIMEOUT + 1);
      apply_stimulus(1'b0, 1'b0, 22'h0, 8'h00, 1'b1, 1'b0, 22'h1F0F0F, 8'h00);
      drain();
      check_output("to_b_rdata", 32'(b_rdata), 32'hFF);
      check_output("to_b_busy", 32'(b_busy), 32'h0);
      mem_return(8'h77);
      check_output("stray_b_rdata_en", 32'(b_rdata_en), 32'h0);
      check_output("stray_a_rdata_en", 32'(a_rdata_en), 32'h0);
      check_output("stray_b_rdata", 32'(b_rdata), 32'hFF);

      $display("[TB] reset while waiting for read data");
      c = cyc;
      expect_ev(EV_RD, 22'h155555, 8'h00, c + 2);
      apply_stimulus(1'b1, 1'b0, 22'h155555, 8'h00, 1'b0, 1'b0, 22'h0, 8'h00);
      step(3);
      n_reset = 1'b0;
      #1;
      check_reset_outputs("midreset");
      step(2);
      n_reset = 1'b1;
      step(1);
      mem_return(8'hAA);
      check_output("postreset_a_rdata_en", 32'(a_rdata_en), 32'h0);
      check_output("postreset_a_busy", 32'(a_busy), 32'h0);
      c = cyc;
      expect_ev(EV_RD, 22'h0ABCDE, 8'h00, c + 2);
      expect_ev(EV_A, 22'h0, 8'h96, c + 4);
      apply_stimulus(1'b1, 1'b0, 22'h0ABCDE, 8'h00, 1'b0, 1'b0, 22'h0, 8'h00);
      step(2);
      mem_return(8'h96);
      drain();
      check_output("postreset_a_rdata", 32'(a_rdata), 32'h96);

      step(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
